ctrl_barreira: RTL and testbench

Sequencing controller for the car-park entry barrier. Accepts a validated licence plate (24-bit `matricula` with valid), decides admission against the current occupancy, and drives the barrier through open → hold → close. Holds the open window for a fixed number of cycles, closes early once the car has passed, and reverses on an obstruction while closing. Maintains the park occupancy count from entry passages and exit pulses.

---
 rtl/barreira_pkg.sv | 21 ++
 rtl/ctrl_barreira_if.sv | 14 +
 rtl/contador_tempo.sv | 27 ++
 rtl/ctrl_barreira.sv | 157 +++++++++++++++
 tb/tb_ctrl_barreira.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/barreira_pkg.sv
// Shared types and widths for the car-park entry barrier controller.
package barreira_pkg;

  localparam int MATR_W = 24;
  localparam int OCUP_W = 8;

  typedef enum logic [1:0] {
    FECHADA  = 2'd0,
    A_ABRIR  = 2'd1,
    ABERTA   = 2'd2,
    A_FECHAR = 2'd3
  } estado_t;

  // Timer width: enough bits for the longer of the two reload values, never below one bit.
  function automatic int temp_w(input int aberto_ciclos, input int mov_ciclos);
    int maior;
    maior = (aberto_ciclos > mov_ciclos) ? aberto_ciclos : mov_ciclos;
    return ($clog2(maior) < 1) ? 1 : $clog2(maior);
  endfunction

endpackage

// File: rtl/ctrl_barreira_if.sv
// Plate handshake between the licence-plate reader and the barrier controller.
interface ctrl_barreira_if;
  import barreira_pkg::*;

  logic [MATR_W-1:0] matricula;
  logic              matr_val;
  logic              matr_rdy;

  // Reader side: presents the plate and holds it until accepted.
  modport master (output matricula, output matr_val, input matr_rdy);
  // Controller side.
  modport slave  (input matricula, input matr_val, output matr_rdy);

endinterface

// File: rtl/contador_tempo.sv
// Loadable down-counter shared by the movement and open-hold timers.
module contador_tempo #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         carregar,
  input  logic [W-1:0] carga,
  output logic [W-1:0] valor,
  output logic         zero
);

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      valor <= '0;
    end else if (carregar) begin
      valor <= carga;
    end else if (!zero) begin
      valor <= valor - W'(1);
    end
  end

  assign zero = (valor == '0);

endmodule

// File: rtl/ctrl_barreira.sv
// Entry barrier sequencer: admission against occupancy, open/hold/close with
// early close on passage, reversal on obstruction, and occupancy tracking.
module ctrl_barreira
  import barreira_pkg::*;
#(
  parameter int ABERTO_CICLOS = 6,
  parameter int MOV_CICLOS    = 3,
  parameter int CAPACIDADE    = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_barreira_if.slave    leitor,
  input  logic              sensor_passagem,
  input  logic              saida,
  output logic              barr_abrir,
  output logic              barr_fechar,
  output logic              barr_aberta,
  output logic              rejeitado,
  output logic [MATR_W-1:0] matr_atual,
  output logic [OCUP_W-1:0] ocupados,
  output logic              lotado
);

  localparam int                TEMP_W       = temp_w(ABERTO_CICLOS, MOV_CICLOS);
  localparam logic [TEMP_W-1:0] CARGA_MOV    = TEMP_W'(MOV_CICLOS - 1);
  localparam logic [TEMP_W-1:0] CARGA_ABERTO = TEMP_W'(ABERTO_CICLOS - 1);
  localparam logic [OCUP_W-1:0] OCUP_MAX     = '1;
  localparam logic [OCUP_W-1:0] LIMITE       = OCUP_W'(CAPACIDADE);

  estado_t           estado, estado_n;
  logic              passou, passou_n;
  logic              pronto;
  logic              transf;
  logic              admitir, rejeita, entrada;
  logic              carregar, t_zero;
  logic [TEMP_W-1:0] carga;
  // Remaining count is not needed here; the FSM only reacts to expiry.
  logic [TEMP_W-1:0] tempo_unused;

  assign leitor.matr_rdy = pronto;
  assign transf          = leitor.matr_val && pronto;
  assign lotado          = (ocupados >= LIMITE);

  contador_tempo #(.W(TEMP_W)) u_tempo (
    .clk      (clk),
    .rst_n    (rst_n),
    .carregar (carregar),
    .carga    (carga),
    .valor    (tempo_unused),
    .zero     (t_zero)
  );

  // Next state, timer reloads and the single-cycle decisions of this cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    estado_n = estado;
    passou_n = passou;
    carregar = 1'b0;
    carga    = '0;
    admitir  = 1'b0;
    rejeita  = 1'b0;
    entrada  = 1'b0;
    case (estado)
      FECHADA: begin
        if (transf) begin
          if (lotado) begin
            rejeita = 1'b1;
          end else begin
            admitir  = 1'b1;
            passou_n = 1'b0;
            estado_n = A_ABRIR;
            carregar = 1'b1;
            carga    = CARGA_MOV;
          end
        end
      end
      A_ABRIR: begin
        if (t_zero) begin
          estado_n = ABERTA;
          carregar = 1'b1;
          carga    = CARGA_ABERTO;
        end
      end
      ABERTA: begin
        // A car under the barrier closes early; only the first passage of an admission counts.
        if (sensor_passagem) begin
          estado_n = A_FECHAR;
          carregar = 1'b1;
          carga    = CARGA_MOV;
          if (!passou) begin
            entrada  = 1'b1;
            passou_n = 1'b1;
          end
        end else if (t_zero) begin
          estado_n = A_FECHAR;
          carregar = 1'b1;
          carga    = CARGA_MOV;
        end
      end
      A_FECHAR: begin
        // Obstruction while closing wins over expiry and reopens the barrier.
        if (sensor_passagem) begin
          estado_n = A_ABRIR;
          carregar = 1'b1;
          carga    = CARGA_MOV;
        end else if (t_zero) begin
          estado_n = FECHADA;
        end
      end
      default: estado_n = FECHADA;
    endcase
  end

  // State, passage flag and registered motor/handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado      <= FECHADA;
      passou      <= 1'b0;
      pronto      <= 1'b0;
      barr_abrir  <= 1'b0;
      barr_fechar <= 1'b0;
      barr_aberta <= 1'b0;
      rejeitado   <= 1'b0;
    end else begin
      estado      <= estado_n;
      passou      <= passou_n;
      pronto      <= (estado_n == FECHADA);
      barr_abrir  <= (estado_n == A_ABRIR);
      barr_fechar <= (estado_n == A_FECHAR);
      barr_aberta <= (estado_n == ABERTA);
      rejeitado   <= rejeita;
    end
  end

  // Last admitted plate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      matr_atual <= '0;
    end else if (admitir) begin
      matr_atual <= leitor.matricula;
    end
  end

  // Occupancy: entry and exit in the same cycle cancel; both ends saturate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ocupados <= '0;
    end else begin
      case ({entrada, saida})
        2'b10: if (ocupados != OCUP_MAX) ocupados <= ocupados + OCUP_W'(1);
        2'b01: if (ocupados != '0)       ocupados <= ocupados - OCUP_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_barreira.sv
// Self-checking bench for ctrl_barreira: two instances (default capacity and
// capacity 2) share the stimulus through a selector; expectations come from
// phase-length arithmetic and an event-level occupancy model.
module tb_ctrl_barreira;

  localparam int MOV   = 3;
  localparam int AB    = 6;
  localparam int CAP_A = 100;
  localparam int CAP_B = 2;

  // Expected barrier phase per cycle.
  localparam int F_FECH = 0;
  localparam int F_ABR  = 1;
  localparam int F_ABT  = 2;
  localparam int F_FCH  = 3;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [23:0] placa_in = '0;
  logic        val    = 1'b0;
  logic        sensor = 1'b0;
  logic        saida  = 1'b0;
  logic        sel    = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          ocup_exp [2];
  logic [23:0] ultima   [2];
  int          fases    [$];

  always #5 clk = ~clk;

  ctrl_barreira_if if_a ();
  ctrl_barreira_if if_b ();

  logic        sens_a, sens_b, sai_a, sai_b;
  logic        a_abrir, a_fechar, a_aberta, a_rej, a_lot;
  logic        b_abrir, b_fechar, b_aberta, b_rej, b_lot;
  logic [23:0] a_atual, b_atual;
  logic [7:0]  a_ocup, b_ocup;

  assign if_a.matricula = placa_in;
  assign if_b.matricula = placa_in;
  assign if_a.matr_val  = val && !sel;
  assign if_b.matr_val  = val && sel;
  assign sens_a         = sensor && !sel;
  assign sens_b         = sensor && sel;
  assign sai_a          = saida && !sel;
  assign sai_b          = saida && sel;

  ctrl_barreira #(.ABERTO_CICLOS(AB), .MOV_CICLOS(MOV), .CAPACIDADE(CAP_A)) dut_a (
    .clk (clk), .rst_n (rst_n), .leitor (if_a),
    .sensor_passagem (sens_a), .saida (sai_a),
    .barr_abrir (a_abrir), .barr_fechar (a_fechar), .barr_aberta (a_aberta),
    .rejeitado (a_rej), .matr_atual (a_atual), .ocupados (a_ocup), .lotado (a_lot)
  );

  ctrl_barreira #(.ABERTO_CICLOS(AB), .MOV_CICLOS(MOV), .CAPACIDADE(CAP_B)) dut_b (
    .clk (clk), .rst_n (rst_n), .leitor (if_b),
    .sensor_passagem (sens_b), .saida (sai_b),
    .barr_abrir (b_abrir), .barr_fechar (b_fechar), .barr_aberta (b_aberta),
    .rejeitado (b_rej), .matr_atual (b_atual), .ocupados (b_ocup), .lotado (b_lot)
  );

  logic        o_abrir, o_fechar, o_aberta, o_rej, o_lot, o_rdy;
  logic [23:0] o_atual;
  logic [7:0]  o_ocup;

  assign o_abrir  = sel ? b_abrir  : a_abrir;
  assign o_fechar = sel ? b_fechar : a_fechar;
  assign o_aberta = sel ? b_aberta : a_aberta;
  assign o_rej    = sel ? b_rej    : a_rej;
  assign o_lot    = sel ? b_lot    : a_lot;
  assign o_rdy    = sel ? if_b.matr_rdy : if_a.matr_rdy;
  assign o_atual  = sel ? b_atual  : a_atual;
  assign o_ocup   = sel ? b_ocup   : a_ocup;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int cap_atual();
    return sel ? CAP_B : CAP_A;
  endfunction

  // Occupancy rule: entry +1, exit -1, both together cancel, saturate at 0 and 255.
  function automatic int novo(input int o, input bit e, input bit s);
    if (e && !s) return (o < 255) ? o + 1 : o;
    if (s && !e) return (o > 0) ? o - 1 : 0;
    return o;
  endfunction

  task automatic seg(input int f, input int n);
    repeat (n) fases.push_back(f);
  endtask

  task automatic check_saidas(input int i, input int f, input logic rdy_exp);
    check($sformatf("abrir[%0d]", i),     o_abrir,  f == F_ABR);
    check($sformatf("aberta[%0d]", i),    o_aberta, f == F_ABT);
    check($sformatf("fechar[%0d]", i),    o_fechar, f == F_FCH);
    check($sformatf("rdy[%0d]", i),       o_rdy,    rdy_exp);
    check($sformatf("rejeitado[%0d]", i), o_rej,    1'b0);
    check($sformatf("ocupados[%0d]", i),  o_ocup,   ocup_exp[sel]);
    check($sformatf("lotado[%0d]", i),    o_lot,    ocup_exp[sel] >= cap_atual());
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_abrir"},  o_abrir,  1'b0);
    check({tag, "_fechar"}, o_fechar, 1'b0);
    check({tag, "_aberta"}, o_aberta, 1'b0);
    check({tag, "_rej"},    o_rej,    1'b0);
    check({tag, "_ocup"},   o_ocup,   0);
    check({tag, "_lotado"}, o_lot,    1'b0);
    check({tag, "_atual"},  o_atual,  0);
  endtask

  task automatic espera_rdy();
    for (int c = 0; c < 40 && o_rdy !== 1'b1; c++) @(negedge clk);
    check("espera_rdy", o_rdy, 1'b1);
  endtask

  // One admission: expected phases come from the queue, sensor/exit per cycle from bit vectors.
  task automatic janela(input logic [23:0] placa, input logic [63:0] sens_v,
                        input logic [63:0] said_v, input int ent_i);
    int n;
    espera_rdy();
    placa_in = placa;
    val      = 1'b1;
    @(negedge clk);
    val         = 1'b0;
    ultima[sel] = placa;
    n           = fases.size();
    for (int i = 1; i <= n + 1; i++) begin
      check_saidas(i, (i <= n) ? fases[i-1] : F_FECH, i > n);
      if (i == 1) check("matr_atual", o_atual, placa);
      sensor        = sens_v[i];
      saida         = said_v[i];
      ocup_exp[sel] = novo(ocup_exp[sel], i == ent_i, said_v[i]);
      @(negedge clk);
    end
    sensor = 1'b0;
    saida  = 1'b0;
    fases.delete();
  endtask

  task automatic pulso_saida(input string tag);
    saida         = 1'b1;
    ocup_exp[sel] = novo(ocup_exp[sel], 1'b0, 1'b1);
    @(negedge clk);
    saida = 1'b0;
    check({tag, "_ocup"},   o_ocup, ocup_exp[sel]);
    check({tag, "_lotado"}, o_lot,  ocup_exp[sel] >= cap_atual());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int j;
    ocup_exp = '{0, 0};
    ultima   = '{default: '0};

    // Reset state.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_pos_reset", o_rdy, 1'b1);

    // Admission with no passage: 3 opening, 6 open, 3 closing, ready at cycle 13.
    seg(F_ABR, MOV); seg(F_ABT, AB); seg(F_FCH, MOV);
    janela(24'hABC123, '0, '0, 0);

    // Passage two cycles into the open window, held 4 cycles: counted once,
    // closes next cycle, still present while closing so it reopens.
    seg(F_ABR, MOV); seg(F_ABT, 3); seg(F_FCH, 1);
    seg(F_ABR, MOV); seg(F_ABT, AB); seg(F_FCH, MOV);
    janela(24'h5A0001, 64'h3C0, '0, 6);

    // Counted passage, then an obstruction pulse while closing.
    seg(F_ABR, MOV); seg(F_ABT, 1); seg(F_FCH, 2);
    seg(F_ABR, MOV); seg(F_ABT, AB); seg(F_FCH, MOV);
    janela(24'h5A0002, 64'h50, '0, 4);

    // Random plates, passage offsets and exit pulses.
    for (int r = 0; r < 6; r++) begin
      int jr;
      int n;
      int s;
      jr = $urandom_range(AB - 1, 0);
      n  = 2 * MOV + jr + 1;
      s  = $urandom_range(n, 1);
      seg(F_ABR, MOV); seg(F_ABT, jr + 1); seg(F_FCH, MOV);
      janela(24'($urandom), 64'd1 << (MOV + 1 + jr),
             (r % 2 == 1) ? (64'd1 << s) : 64'd0, MOV + 1 + jr);
    end

    // Bring the count to 5.
    while (ocup_exp[0] < 5) begin
      seg(F_ABR, MOV); seg(F_ABT, 1); seg(F_FCH, MOV);
      janela(24'($urandom), 64'd1 << (MOV + 1), '0, MOV + 1);
    end
    while (ocup_exp[0] > 5) pulso_saida("ajuste");
    check("ocup_antes_simult", o_ocup, 5);

    // Passage coinciding with an exit pulse leaves the count at 5.
    j = $urandom_range(AB - 1, 0);
    seg(F_ABR, MOV); seg(F_ABT, j + 1); seg(F_FCH, MOV);
    janela(24'h00C0DE, 64'd1 << (MOV + 1 + j), 64'd1 << (MOV + 1 + j), MOV + 1 + j);
    check("ocup_simult", o_ocup, 5);

    // Reset while open with 3 cars inside.
    pulso_saida("desce4");
    pulso_saida("desce3");
    check("ocup_antes_reset", o_ocup, 3);
    espera_rdy();
    placa_in = 24'h777777;
    val      = 1'b1;
    @(negedge clk);
    val = 1'b0;
    repeat (MOV + 1) @(negedge clk);
    check("aberta_antes_reset", o_aberta, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset("reset_async");
    ocup_exp = '{0, 0};
    ultima   = '{default: '0};
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rdy_apos_reset", o_rdy, 1'b1);
    check("abrir_apos_reset", o_abrir, 1'b0);
    check("aberta_apos_reset", o_aberta, 1'b0);

    // Exit pulse with an empty park saturates at 0.
    pulso_saida("saida_zero");
    check("ocup_zero", o_ocup, 0);

    // Full park on the capacity-2 instance.
    sel = 1'b1;
    @(negedge clk);
    repeat (2) begin
      seg(F_ABR, MOV); seg(F_ABT, 1); seg(F_FCH, MOV);
      janela(24'($urandom), 64'd1 << (MOV + 1), '0, MOV + 1);
    end
    check("lotado_cheio", o_lot, 1'b1);
    espera_rdy();
    placa_in = 24'hDEAD01;
    val      = 1'b1;
    @(negedge clk);
    val = 1'b0;
    check("rejeitado", o_rej, 1'b1);
    check("abrir_rejeitado", o_abrir, 1'b0);
    check("atual_inalterada", o_atual, ultima[1]);
    check("rdy_rejeitado", o_rdy, 1'b1);
    @(negedge clk);
    check("rejeitado_1ciclo", o_rej, 1'b0);
    check("abrir_apos_rej", o_abrir, 1'b0);
    pulso_saida("saida_cheio");
    check("lotado_livre", o_lot, 1'b0);
    seg(F_ABR, MOV); seg(F_ABT, AB); seg(F_FCH, MOV);
    janela(24'hDEAD02, '0, '0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
